// File: rtl/chrono_lap.sv
// chrono_lap: run/pause/clear stopwatch with a programmable ms prescaler and binary ms/sec/min/hs fields.
// Optional lap-capture register, enabled by defining CHRONO_LAP_EN.
module chrono_lap #(
    parameter int CLK_PER_MS = 50000,
    parameter int HOURS_MAX  = 24,
    parameter int HS_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stop,
    input  logic            clear,
    input  logic            lap,
    output logic [9:0]      ms,
    output logic [5:0]      sec,
    output logic [5:0]      min,
    output logic [HS_W-1:0] hs,
    output logic            running,
    output logic            wrap,
    output logic [9:0]      lap_ms,
    output logic [5:0]      lap_sec,
    output logic [5:0]      lap_min,
    output logic [HS_W-1:0] lap_hs,
    output logic            lap_valid
);

    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam logic [HS_W-1:0]  HS_LAST  = HS_W'(HOURS_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [9:0]       ms_q, ms_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [HS_W-1:0]  hs_q, hs_d;
    logic             wrap_q, wrap_d;
    logic             advance, tick, msWrap, secWrap, minWrap, hsWrap;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // The current state decides advancing, so the RUN->PAUSE edge still counts and PAUSE->RUN does not.
    always_comb begin
        advance    = (state_q == RUN) && !clear;
        tick       = advance && (prescale_q == PRE_LAST);
        msWrap     = tick && (ms_q == 10'd999);
        secWrap    = msWrap && (sec_q == 6'd59);
        minWrap    = secWrap && (min_q == 6'd59);
        hsWrap     = minWrap && (hs_q == HS_LAST);
        prescale_d = prescale_q;
        ms_d       = ms_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hs_d       = hs_q;
        wrap_d     = 1'b0;
        if (clear) begin
            prescale_d = '0;
            ms_d       = '0;
            sec_d      = '0;
            min_d      = '0;
            hs_d       = '0;
        end else begin
            if (advance) prescale_d = tick ? '0 : prescale_q + 1'b1;
            if (tick)    ms_d  = msWrap  ? 10'd0 : ms_q + 10'd1;
            if (msWrap)  sec_d = secWrap ? 6'd0  : sec_q + 6'd1;
            if (secWrap) min_d = minWrap ? 6'd0  : min_q + 6'd1;
            if (minWrap) hs_d  = hsWrap  ? '0    : hs_q + 1'b1;
            wrap_d = hsWrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            ms_q       <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hs_q       <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            ms_q       <= ms_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hs_q       <= hs_d;
            wrap_q     <= wrap_d;
        end
    end

    assign ms      = ms_q;
    assign sec     = sec_q;
    assign min     = min_q;
    assign hs      = hs_q;
    assign running = (state_q == RUN);
    assign wrap    = wrap_q;

`ifdef CHRONO_LAP_EN
    logic [9:0]      lapMs_q, lapMs_d;
    logic [5:0]      lapSec_q, lapSec_d;
    logic [5:0]      lapMin_q, lapMin_d;
    logic [HS_W-1:0] lapHs_q, lapHs_d;
    logic            lapValid_q, lapValid_d;
    logic            capture;

    // Capture samples the registered fields, so a lap on a tick edge keeps the pre-increment time.
    always_comb begin
        capture    = lap && !clear && ((state_q == RUN) || (state_q == PAUSE));
        lapMs_d    = lapMs_q;
        lapSec_d   = lapSec_q;
        lapMin_d   = lapMin_q;
        lapHs_d    = lapHs_q;
        lapValid_d = lapValid_q;
        if (clear) begin
            lapValid_d = 1'b0;
        end else if (capture) begin
            lapMs_d    = ms_q;
            lapSec_d   = sec_q;
            lapMin_d   = min_q;
            lapHs_d    = hs_q;
            lapValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lapMs_q    <= '0;
            lapSec_q   <= '0;
            lapMin_q   <= '0;
            lapHs_q    <= '0;
            lapValid_q <= 1'b0;
        end else begin
            lapMs_q    <= lapMs_d;
            lapSec_q   <= lapSec_d;
            lapMin_q   <= lapMin_d;
            lapHs_q    <= lapHs_d;
            lapValid_q <= lapValid_d;
        end
    end

    assign lap_ms    = lapMs_q;
    assign lap_sec   = lapSec_q;
    assign lap_min   = lapMin_q;
    assign lap_hs    = lapHs_q;
    assign lap_valid = lapValid_q;
`else
    logic unusedLap;
    assign unusedLap = lap;
    assign lap_ms    = '0;
    assign lap_sec   = '0;
    assign lap_min   = '0;
    assign lap_hs    = '0;
    assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_chrono_lap.sv
// Directed bench for chrono_lap: one fast-prescaler instance for control/timing, one for the hour wrap.
module tb_chrono_lap;

`ifdef CHRONO_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk;
    logic rstN;
    logic startStop, clearIn, lapIn, startStopB;

    logic [9:0] msA, lapMsA, msB, lapMsB;
    logic [5:0] secA, minA, lapSecA, lapMinA, secB, minB, lapSecB, lapMinB;
    logic [4:0] hsA, lapHsA;
    logic [0:0] hsB, lapHsB;
    logic       runningA, wrapA, lapValidA, runningB, wrapB, lapValidB;

    int checks = 0;
    int errors = 0;

    chrono_lap #(.CLK_PER_MS(4), .HOURS_MAX(24), .HS_W(5)) dutA (
        .clk(clk), .rst(rstN), .start_stop(startStop), .clear(clearIn), .lap(lapIn),
        .ms(msA), .sec(secA), .min(minA), .hs(hsA), .running(runningA), .wrap(wrapA),
        .lap_ms(lapMsA), .lap_sec(lapSecA), .lap_min(lapMinA), .lap_hs(lapHsA),
        .lap_valid(lapValidA)
    );

    chrono_lap #(.CLK_PER_MS(1), .HOURS_MAX(2), .HS_W(1)) dutB (
        .clk(clk), .rst(rstN), .start_stop(startStopB), .clear(1'b0), .lap(1'b0),
        .ms(msB), .sec(secB), .min(minB), .hs(hsB), .running(runningB), .wrap(wrapB),
        .lap_ms(lapMsB), .lap_sec(lapSecB), .lap_min(lapMinB), .lap_hs(lapHsB),
        .lap_valid(lapValidB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the inputs for exactly one sampling edge, starting and ending on a falling edge.
    task automatic applyStimulus(input logic ss, input logic clr, input logic lp, input logic ssB);
        startStop  = ss;
        clearIn    = clr;
        lapIn      = lp;
        startStopB = ssB;
        @(negedge clk);
        startStop  = 1'b0;
        clearIn    = 1'b0;
        lapIn      = 1'b0;
        startStopB = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstN = 1'b0;
        startStop = 1'b0; clearIn = 1'b0; lapIn = 1'b0; startStopB = 1'b0;
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(1);
        checkOutput("reset_ms", msA, 0);
        checkOutput("reset_running", runningA, 0);
        checkOutput("reset_wrap", wrapA, 0);
        checkOutput("reset_lap_valid", lapValidA, 0);

        // Start latency: start sampled at edge 0.
        applyStimulus(1, 0, 0, 0);
        checkOutput("start_running", runningA, 1);
        checkOutput("start_ms_e0", msA, 0);
        waitCycles(3);
        checkOutput("start_ms_e3", msA, 0);
        waitCycles(1);
        checkOutput("start_ms_e4", msA, 1);
        waitCycles(36);
        checkOutput("start_ms_e40", msA, 10);

        // Clear beats start_stop in the same cycle.
        applyStimulus(1, 1, 0, 0);
        checkOutput("prio_running", runningA, 0);
        checkOutput("prio_ms", msA, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("prio_restart", runningA, 1);

        // Lap at ms=5 (sampled edge 21), then a lap coincident with the 6->7 tick (edge 28).
        waitCycles(20);
        checkOutput("lap_pre_ms", msA, 5);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lap_ms", lapMsA, LAP_EN ? 5 : 0);
        checkOutput("lap_valid", lapValidA, LAP_EN ? 1 : 0);
        checkOutput("lap_live_ms", msA, 5);
        waitCycles(3);
        checkOutput("lap_live_ms_e24", msA, 6);
        checkOutput("lap_hold", lapMsA, LAP_EN ? 5 : 0);
        waitCycles(3);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lap_tick_ms", msA, 7);
        checkOutput("lap_tick_capture", lapMsA, LAP_EN ? 6 : 0);

        // Pause/resume: start edge 0, pause edge 6, lap in PAUSE at edge 100, resume edge 106.
        applyStimulus(0, 1, 0, 0);
        checkOutput("clear_lap_valid", lapValidA, 0);
        applyStimulus(1, 0, 0, 0);
        waitCycles(5);
        applyStimulus(1, 0, 0, 0);
        checkOutput("pause_running", runningA, 0);
        checkOutput("pause_ms_e6", msA, 1);
        waitCycles(93);
        applyStimulus(0, 0, 1, 0);
        checkOutput("pause_lap_ms", lapMsA, LAP_EN ? 1 : 0);
        waitCycles(5);
        checkOutput("pause_ms_e105", msA, 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resume_running", runningA, 1);
        checkOutput("resume_ms_e106", msA, 1);
        waitCycles(1);
        checkOutput("resume_ms_e107", msA, 1);
        waitCycles(1);
        checkOutput("resume_ms_e108", msA, 2);

        // Asynchronous reset between edges while counting at ms=7.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        waitCycles(28);
        checkOutput("async_pre_ms", msA, 7);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_ms", msA, 0);
        checkOutput("async_running", runningA, 0);
        checkOutput("async_lap_valid", lapValidA, 0);
        #1 rstN = 1'b1;
        waitCycles(3);
        checkOutput("async_idle_ms", msA, 0);
        checkOutput("async_idle_running", runningA, 0);

        // Hour wrap on the HOURS_MAX=2 instance: start, pause, preload the last ms of the last hour.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrapB_paused", runningB, 0);
        force dutB.ms_q  = 10'd999;
        force dutB.sec_q = 6'd59;
        force dutB.min_q = 6'd59;
        force dutB.hs_q  = 1'b1;
        #1;
        release dutB.ms_q;
        release dutB.sec_q;
        release dutB.min_q;
        release dutB.hs_q;
        waitCycles(1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrapB_resume_ms", msB, 999);
        checkOutput("wrapB_resume_wrap", wrapB, 0);
        waitCycles(1);
        checkOutput("wrapB_ms", msB, 0);
        checkOutput("wrapB_sec", secB, 0);
        checkOutput("wrapB_min", minB, 0);
        checkOutput("wrapB_hs", hsB, 0);
        checkOutput("wrapB_pulse", wrapB, 1);
        checkOutput("wrapB_running", runningB, 1);
        waitCycles(1);
        checkOutput("wrapB_pulse_end", wrapB, 0);
        checkOutput("wrapB_ms_next", msB, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chrono_lap.md
Name: chrono_lap

Overview:
Parametrised stopwatch: a next-generation chrono with a programmable clock-to-millisecond prescaler, configurable hour wrap, and explicit run/pause/clear control. It adds an hours-wrap pulse and an optional lap-capture register.
It sits between the board clock and the display/readout logic. Its outputs are binary time fields (ms, sec, min, hs), not BCD.

Parameters:
CLK_PER_MS, 50000, clk cycles per 1 ms tick; legal range >=1, where 1 means a tick every cycle.
HOURS_MAX, 24, hs counts 0..HOURS_MAX-1 then wraps; legal range 1..2**HS_W.
HS_W, 5, width of the hs and lap_hs fields.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start_stop  in  1  one-cycle pulse; toggles between RUN and PAUSE, or starts from IDLE.
clear  in  1  synchronous; returns to IDLE with all counters zeroed.
lap  in  1  one-cycle pulse; captures the current time (feature-gated).
ms  out  10  milliseconds, 0..999.
sec  out  6  seconds, 0..59.
min  out  6  minutes, 0..59.
hs  out  HS_W  hours, 0..HOURS_MAX-1.
running  out  1  high while in RUN.
wrap  out  1  one-cycle pulse when hs wraps to 0.
lap_ms / lap_sec / lap_min / lap_hs  out  10/6/6/HS_W  captured time.
lap_valid  out  1  a capture is held.

Behaviour:
- Reset (rst=0): takes effect immediately, with no clock edge.
  - State goes to IDLE.
  - Prescaler, ms, sec, min and hs go to 0.
  - running=0, wrap=0, all lap_* outputs=0, lap_valid=0.
- States are IDLE, RUN and PAUSE. All outputs are registered.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - clear in any state -> IDLE, zeroing the prescaler and ms/sec/min/hs and clearing lap_valid.
  - clear has priority over start_stop and lap in the same cycle.
- Prescaler:
  - Advances only on edges where the current state is RUN. This includes the edge on which a RUN->PAUSE pulse is sampled.
  - When it reaches CLK_PER_MS-1, it reloads 0 and ms increments on the same edge.
  - PAUSE holds the prescaler value; it is not reset. Resuming continues the partial millisecond.
  - The PAUSE->RUN edge does not advance the prescaler.
- Latency: with start_stop sampled at edge N from IDLE, running=1 after edge N and ms=1 after edge N+CLK_PER_MS.
- Cascade, all on the same edge as the tick:
  - ms 999->0 carries into sec.
  - sec 59->0 carries into min.
  - min 59->0 carries into hs.
  - hs HOURS_MAX-1->0 asserts wrap for exactly one cycle. Counting continues and running stays 1.
- Field arithmetic is unsigned. No field ever exceeds its stated maximum.
- A tick coinciding with a RUN->PAUSE pulse is applied before pausing.
- start_stop held high for several cycles toggles on every sampled cycle. Upstream is responsible for pulsing it.

Optional Feature:
Macro CHRONO_LAP_EN.
- Defined:
  - A lap pulse in RUN or PAUSE copies the ms/sec/min/hs values as they stand before that edge into the lap_* outputs.
  - lap_valid goes to 1 after that edge and stays set until clear or reset.
  - A later lap pulse overwrites the capture.
  - lap in IDLE is ignored.
  - A lap pulse coincident with a tick captures the pre-increment value.
- Not defined: the lap input is ignored; all lap_* outputs and lap_valid are tied to 0. The port list is unchanged.

Test Plan:
1. Async reset: CLK_PER_MS=4; run to ms=7, drive rst=0 between clock edges -> ms/sec/min/hs=0, running=0 and lap_valid=0 before the next edge; rst=1 -> stays IDLE with ms=0.
2. Start latency: CLK_PER_MS=4; start_stop pulse sampled at edge 0 -> running=1 after edge 0, ms=1 after edge 4, ms=10 after edge 40.
3. Full cascade: HOURS_MAX=2; force the count to hs=1, min=59, sec=59, ms=999 -> the next tick gives all fields 0, wrap=1 for exactly one cycle, running=1.
4. Pause/resume: CLK_PER_MS=4; start at edge 0, pause at edge 6 (ms=1), idle 100 cycles -> ms stays 1; resume at edge 106 -> ms=2 after edge 108.
5. Priority: in RUN, clear and start_stop in the same cycle -> IDLE, all fields 0, running=0; the next start_stop -> RUN.
6. Lap capture: with CHRONO_LAP_EN, pulse lap at ms=5 -> lap_ms=5 and lap_valid=1 while ms keeps counting; without the macro, the same stimulus leaves lap_valid=0 and lap_ms=0.
